axi_arbiter_2x1: RTL and testbench

Two-master to one-slave AXI4 arbiter placed between the core's instruction fetch port (M0) and load/store port (M1) and the single simulated-memory slave port.
Read and write paths are arbitrated independently, each with a round-robin grant.
Each path allows one outstanding transaction; bursts are carried whole.
The ID, length, size and burst fields pass through unchanged.

---
 rtl/axi_pkg.sv | 17 +
 rtl/rr_arb2.sv | 20 ++
 rtl/axi_arbiter_2x1.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_arbiter_2x1.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and arbiter FSM state types.
// Contents: response codes, burst codes, read/write FSM state enums.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// Ports: req_i[1:0] requests, last_grant_i master granted last time,
//        grant_o index of the winning master (meaningless when req_i == 0).
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = 1'b0;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_arbiter_2x1.sv
// Two-master to one-slave AXI4 arbiter (M0 = fetch, M1 = load/store).
// Read and write paths are arbitrated independently, one outstanding
// transaction each, bursts carried whole, ID/len/size/burst passed through.
// Ports: aclk/aresetn (sync, active-low); m{0,1}_{ar,r,aw,w,b}* master side;
//        s_{ar,r,aw,w,b}* slave side.
//
// state  | meaning
// R_IDLE | no read in flight, waiting for any arvalid
// R_ADDR | AR of granted master forwarded to slave
// R_DATA | R beats routed to granted master until rlast
// W_IDLE | no write in flight, waiting for any awvalid
// W_XFER | AW and W of granted master forwarded together
// W_RESP | B routed to granted master
module axi_arbiter_2x1
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] m0_araddr_i,   m1_araddr_i,
  input  logic [ID_W-1:0]   m0_arid_i,     m1_arid_i,
  input  logic [7:0]        m0_arlen_i,    m1_arlen_i,
  input  logic [2:0]        m0_arsize_i,   m1_arsize_i,
  input  logic [1:0]        m0_arburst_i,  m1_arburst_i,
  input  logic              m0_arvalid_i,  m1_arvalid_i,
  output logic              m0_arready_o,  m1_arready_o,
  output logic [DATA_W-1:0] m0_rdata_o,    m1_rdata_o,
  output logic [ID_W-1:0]   m0_rid_o,      m1_rid_o,
  output logic [1:0]        m0_rresp_o,    m1_rresp_o,
  output logic              m0_rlast_o,    m1_rlast_o,
  output logic              m0_rvalid_o,   m1_rvalid_o,
  input  logic              m0_rready_i,   m1_rready_i,
  input  logic [ADDR_W-1:0] m0_awaddr_i,   m1_awaddr_i,
  input  logic [ID_W-1:0]   m0_awid_i,     m1_awid_i,
  input  logic [7:0]        m0_awlen_i,    m1_awlen_i,
  input  logic [2:0]        m0_awsize_i,   m1_awsize_i,
  input  logic [1:0]        m0_awburst_i,  m1_awburst_i,
  input  logic              m0_awvalid_i,  m1_awvalid_i,
  output logic              m0_awready_o,  m1_awready_o,
  input  logic [DATA_W-1:0] m0_wdata_i,    m1_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,  m1_wstrb_i,
  input  logic              m0_wlast_i,    m1_wlast_i,
  input  logic              m0_wvalid_i,   m1_wvalid_i,
  output logic              m0_wready_o,   m1_wready_o,
  output logic [ID_W-1:0]   m0_bid_o,      m1_bid_o,
  output logic [1:0]        m0_bresp_o,    m1_bresp_o,
  output logic              m0_bvalid_o,   m1_bvalid_o,
  input  logic              m0_bready_i,   m1_bready_i,
  output logic [ADDR_W-1:0] s_araddr_o,
  output logic [ID_W-1:0]   s_arid_o,
  output logic [7:0]        s_arlen_o,
  output logic [2:0]        s_arsize_o,
  output logic [1:0]        s_arburst_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [ID_W-1:0]   s_rid_i,
  input  logic [1:0]        s_rresp_i,
  input  logic              s_rlast_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o,
  output logic [ADDR_W-1:0] s_awaddr_o,
  output logic [ID_W-1:0]   s_awid_o,
  output logic [7:0]        s_awlen_o,
  output logic [2:0]        s_awsize_o,
  output logic [1:0]        s_awburst_o,
  output logic              s_awvalid_o,
  input  logic              s_awready_i,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  output logic              s_wlast_o,
  output logic              s_wvalid_o,
  input  logic              s_wready_i,
  input  logic [ID_W-1:0]   s_bid_i,
  input  logic [1:0]        s_bresp_i,
  input  logic              s_bvalid_i,
  output logic              s_bready_o
);

  logic [ADDR_W-1:0]   araddr [2], awaddr [2];
  logic [ID_W-1:0]     arid [2], awid [2];
  logic [7:0]          arlen [2], awlen [2];
  logic [2:0]          arsize [2], awsize [2];
  logic [1:0]          arburst [2], awburst [2];
  logic [DATA_W-1:0]   wdata [2];
  logic [DATA_W/8-1:0] wstrb [2];
  logic [1:0] arvalid, rready, awvalid, wvalid, wlast, bready;
  logic [1:0] arready, rvalid, awready, wready, bvalid;

  assign araddr  = '{m0_araddr_i,  m1_araddr_i};
  assign arid    = '{m0_arid_i,    m1_arid_i};
  assign arlen   = '{m0_arlen_i,   m1_arlen_i};
  assign arsize  = '{m0_arsize_i,  m1_arsize_i};
  assign arburst = '{m0_arburst_i, m1_arburst_i};
  assign awaddr  = '{m0_awaddr_i,  m1_awaddr_i};
  assign awid    = '{m0_awid_i,    m1_awid_i};
  assign awlen   = '{m0_awlen_i,   m1_awlen_i};
  assign awsize  = '{m0_awsize_i,  m1_awsize_i};
  assign awburst = '{m0_awburst_i, m1_awburst_i};
  assign wdata   = '{m0_wdata_i,   m1_wdata_i};
  assign wstrb   = '{m0_wstrb_i,   m1_wstrb_i};
  assign arvalid = {m1_arvalid_i, m0_arvalid_i};
  assign rready  = {m1_rready_i,  m0_rready_i};
  assign awvalid = {m1_awvalid_i, m0_awvalid_i};
  assign wvalid  = {m1_wvalid_i,  m0_wvalid_i};
  assign wlast   = {m1_wlast_i,   m0_wlast_i};
  assign bready  = {m1_bready_i,  m0_bready_i};

  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  logic rgrant_q, rgrant_d, wgrant_q, wgrant_d;
  // last_q = 1 after reset so a simultaneous first request goes to M0.
  logic rd_last_q, rd_last_d, wr_last_q, wr_last_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rarb_grant, warb_grant, aw_hs, wl_hs;

  rr_arb2 u_rd_arb (.req_i(arvalid), .last_grant_i(rd_last_q), .grant_o(rarb_grant));
  rr_arb2 u_wr_arb (.req_i(awvalid), .last_grant_i(wr_last_q), .grant_o(warb_grant));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rgrant_q   <= 1'b0;
      wgrant_q   <= 1'b0;
      rd_last_q  <= 1'b1;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rgrant_q   <= rgrant_d;
      wgrant_q   <= wgrant_d;
      rd_last_q  <= rd_last_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rgrant_d    = rgrant_q;
    rd_last_d   = rd_last_q;
    s_araddr_o  = '0;
    s_arid_o    = '0;
    s_arlen_o   = '0;
    s_arsize_o  = '0;
    s_arburst_o = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    arready     = '0;
    rvalid      = '0;
    case (rd_state_q)
      R_IDLE: begin
        if (|arvalid) begin
          rgrant_d   = rarb_grant;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        s_araddr_o        = araddr[rgrant_q];
        s_arid_o          = arid[rgrant_q];
        s_arlen_o         = arlen[rgrant_q];
        s_arsize_o        = arsize[rgrant_q];
        s_arburst_o       = arburst[rgrant_q];
        s_arvalid_o       = arvalid[rgrant_q];
        arready[rgrant_q] = s_arready_i;
        if (s_arvalid_o && s_arready_i) rd_state_d = R_DATA;
      end
      R_DATA: begin
        s_rready_o       = rready[rgrant_q];
        rvalid[rgrant_q] = s_rvalid_i;
        if (s_rvalid_i && s_rready_o && s_rlast_i) begin
          rd_state_d = R_IDLE;
          rd_last_d  = rgrant_q;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wgrant_d    = wgrant_q;
    wr_last_d   = wr_last_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_hs       = 1'b0;
    wl_hs       = 1'b0;
    s_awaddr_o  = '0;
    s_awid_o    = '0;
    s_awlen_o   = '0;
    s_awsize_o  = '0;
    s_awburst_o = '0;
    s_awvalid_o = 1'b0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    s_wlast_o   = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    awready     = '0;
    wready      = '0;
    bvalid      = '0;
    case (wr_state_q)
      W_IDLE: begin
        if (|awvalid) begin
          wgrant_d   = warb_grant;
          wr_state_d = W_XFER;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      W_XFER: begin
        s_awaddr_o        = awaddr[wgrant_q];
        s_awid_o          = awid[wgrant_q];
        s_awlen_o         = awlen[wgrant_q];
        s_awsize_o        = awsize[wgrant_q];
        s_awburst_o       = awburst[wgrant_q];
        s_awvalid_o       = awvalid[wgrant_q] & ~aw_done_q;
        awready[wgrant_q] = s_awready_i & ~aw_done_q;
        s_wdata_o         = wdata[wgrant_q];
        s_wstrb_o         = wstrb[wgrant_q];
        s_wlast_o         = wlast[wgrant_q];
        // W is also fenced after wlast in case it completes before AW.
        s_wvalid_o        = wvalid[wgrant_q] & ~w_done_q;
        wready[wgrant_q]  = s_wready_i & ~w_done_q;
        aw_hs = s_awvalid_o & s_awready_i;
        wl_hs = s_wvalid_o & s_wready_i & s_wlast_o;
        if (aw_hs) aw_done_d = 1'b1;
        if (wl_hs) w_done_d = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || wl_hs)) wr_state_d = W_RESP;
      end
      W_RESP: begin
        s_bready_o       = bready[wgrant_q];
        bvalid[wgrant_q] = s_bvalid_i;
        if (s_bvalid_i && s_bready_o) begin
          wr_state_d = W_IDLE;
          wr_last_d  = wgrant_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  logic r_sel0, r_sel1, b_sel0, b_sel1;
  assign r_sel0 = (rd_state_q == R_DATA) && !rgrant_q;
  assign r_sel1 = (rd_state_q == R_DATA) &&  rgrant_q;
  assign b_sel0 = (wr_state_q == W_RESP) && !wgrant_q;
  assign b_sel1 = (wr_state_q == W_RESP) &&  wgrant_q;

  assign m0_arready_o = arready[0];
  assign m1_arready_o = arready[1];
  assign m0_rvalid_o  = rvalid[0];
  assign m1_rvalid_o  = rvalid[1];
  assign m0_rdata_o   = r_sel0 ? s_rdata_i : '0;
  assign m1_rdata_o   = r_sel1 ? s_rdata_i : '0;
  assign m0_rid_o     = r_sel0 ? s_rid_i : '0;
  assign m1_rid_o     = r_sel1 ? s_rid_i : '0;
  assign m0_rresp_o   = r_sel0 ? s_rresp_i : '0;
  assign m1_rresp_o   = r_sel1 ? s_rresp_i : '0;
  assign m0_rlast_o   = r_sel0 & s_rlast_i;
  assign m1_rlast_o   = r_sel1 & s_rlast_i;
  assign m0_awready_o = awready[0];
  assign m1_awready_o = awready[1];
  assign m0_wready_o  = wready[0];
  assign m1_wready_o  = wready[1];
  assign m0_bvalid_o  = bvalid[0];
  assign m1_bvalid_o  = bvalid[1];
  assign m0_bid_o     = b_sel0 ? s_bid_i : '0;
  assign m1_bid_o     = b_sel1 ? s_bid_i : '0;
  assign m0_bresp_o   = b_sel0 ? s_bresp_i : '0;
  assign m1_bresp_o   = b_sel1 ? s_bresp_i : '0;

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// Directed bench for axi_arbiter_2x1: reset state, single read, read
// contention/round-robin, burst with stalled competitor, write with delayed
// awready, concurrent read+write, AW-before-W ordering, reset mid-burst.
module tb_axi_arbiter_2x1;
  import axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic aclk, aresetn;
  logic [ADDR_W-1:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
  logic [ID_W-1:0]   m0_arid, m1_arid, m0_awid, m1_awid;
  logic [7:0]        m0_arlen, m1_arlen, m0_awlen, m1_awlen;
  logic [2:0]        m0_arsize, m1_arsize, m0_awsize, m1_awsize;
  logic [1:0]        m0_arburst, m1_arburst, m0_awburst, m1_awburst;
  logic m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ID_W-1:0]   m0_rid, m1_rid;
  logic [1:0]        m0_rresp, m1_rresp;
  logic m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [DATA_W-1:0]   m0_wdata, m1_wdata;
  logic [DATA_W/8-1:0] m0_wstrb, m1_wstrb;
  logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [ID_W-1:0] m0_bid, m1_bid;
  logic [1:0]      m0_bresp, m1_bresp;
  logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [ID_W-1:0]   s_arid, s_awid, s_rid, s_bid;
  logic [7:0]        s_arlen, s_awlen;
  logic [2:0]        s_arsize, s_awsize;
  logic [1:0]        s_arburst, s_awburst, s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [DATA_W-1:0]   s_rdata, s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

  int n_checks = 0;
  int n_errors = 0;

  axi_arbiter_2x1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr_i(m0_araddr), .m1_araddr_i(m1_araddr),
    .m0_arid_i(m0_arid), .m1_arid_i(m1_arid),
    .m0_arlen_i(m0_arlen), .m1_arlen_i(m1_arlen),
    .m0_arsize_i(m0_arsize), .m1_arsize_i(m1_arsize),
    .m0_arburst_i(m0_arburst), .m1_arburst_i(m1_arburst),
    .m0_arvalid_i(m0_arvalid), .m1_arvalid_i(m1_arvalid),
    .m0_arready_o(m0_arready), .m1_arready_o(m1_arready),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata),
    .m0_rid_o(m0_rid), .m1_rid_o(m1_rid),
    .m0_rresp_o(m0_rresp), .m1_rresp_o(m1_rresp),
    .m0_rlast_o(m0_rlast), .m1_rlast_o(m1_rlast),
    .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rready_i(m0_rready), .m1_rready_i(m1_rready),
    .m0_awaddr_i(m0_awaddr), .m1_awaddr_i(m1_awaddr),
    .m0_awid_i(m0_awid), .m1_awid_i(m1_awid),
    .m0_awlen_i(m0_awlen), .m1_awlen_i(m1_awlen),
    .m0_awsize_i(m0_awsize), .m1_awsize_i(m1_awsize),
    .m0_awburst_i(m0_awburst), .m1_awburst_i(m1_awburst),
    .m0_awvalid_i(m0_awvalid), .m1_awvalid_i(m1_awvalid),
    .m0_awready_o(m0_awready), .m1_awready_o(m1_awready),
    .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
    .m0_wstrb_i(m0_wstrb), .m1_wstrb_i(m1_wstrb),
    .m0_wlast_i(m0_wlast), .m1_wlast_i(m1_wlast),
    .m0_wvalid_i(m0_wvalid), .m1_wvalid_i(m1_wvalid),
    .m0_wready_o(m0_wready), .m1_wready_o(m1_wready),
    .m0_bid_o(m0_bid), .m1_bid_o(m1_bid),
    .m0_bresp_o(m0_bresp), .m1_bresp_o(m1_bresp),
    .m0_bvalid_o(m0_bvalid), .m1_bvalid_o(m1_bvalid),
    .m0_bready_i(m0_bready), .m1_bready_i(m1_bready),
    .s_araddr_o(s_araddr), .s_arid_o(s_arid), .s_arlen_o(s_arlen),
    .s_arsize_o(s_arsize), .s_arburst_o(s_arburst),
    .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
    .s_rdata_i(s_rdata), .s_rid_i(s_rid), .s_rresp_i(s_rresp),
    .s_rlast_i(s_rlast), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .s_awaddr_o(s_awaddr), .s_awid_o(s_awid), .s_awlen_o(s_awlen),
    .s_awsize_o(s_awsize), .s_awburst_o(s_awburst),
    .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
    .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wlast_o(s_wlast),
    .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
    .s_bid_i(s_bid), .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid),
    .s_bready_o(s_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_ar(input int m, input logic v, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size);
    if (m == 0) begin
      m0_arvalid = v; m0_araddr = addr; m0_arlen = len; m0_arsize = size;
      m0_arburst = BURST_INCR; m0_arid = 4'h1;
    end else begin
      m1_arvalid = v; m1_araddr = addr; m1_arlen = len; m1_arsize = size;
      m1_arburst = BURST_INCR; m1_arid = 4'h2;
    end
  endtask

  task automatic set_aw(input int m, input logic v, input logic [31:0] addr);
    if (m == 0) begin
      m0_awvalid = v; m0_awaddr = addr; m0_awlen = 8'd0; m0_awsize = 3'd3;
      m0_awburst = BURST_INCR; m0_awid = 4'h3;
    end else begin
      m1_awvalid = v; m1_awaddr = addr; m1_awlen = 8'd0; m1_awsize = 3'd3;
      m1_awburst = BURST_INCR; m1_awid = 4'h4;
    end
  endtask

  task automatic set_w(input int m, input logic v, input logic [63:0] data,
                       input logic [7:0] strb);
    if (m == 0) begin
      m0_wvalid = v; m0_wdata = data; m0_wstrb = strb; m0_wlast = v;
    end else begin
      m1_wvalid = v; m1_wdata = data; m1_wstrb = strb; m1_wlast = v;
    end
  endtask

  // Drive one slave R beat and check it lands on master m only.
  task automatic r_beat(input int m, input logic [63:0] data, input logic last, input string tag);
    s_rvalid = 1'b1; s_rdata = data; s_rlast = last; s_rid = (m == 0) ? 4'h1 : 4'h2;
    #1;
    check_eq({tag, " s_rready"}, s_rready, 1'b1);
    if (m == 0) begin
      check_eq({tag, " m0_rvalid"}, m0_rvalid, 1'b1);
      check_eq({tag, " m0_rdata"}, m0_rdata, data);
      check_eq({tag, " m0_rlast"}, m0_rlast, last);
      check_eq({tag, " m1_rvalid"}, m1_rvalid, 1'b0);
    end else begin
      check_eq({tag, " m1_rvalid"}, m1_rvalid, 1'b1);
      check_eq({tag, " m1_rdata"}, m1_rdata, data);
      check_eq({tag, " m1_rlast"}, m1_rlast, last);
      check_eq({tag, " m0_rvalid"}, m0_rvalid, 1'b0);
    end
    tick();
    s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0;
  endtask

  task automatic b_beat(input int m, input logic [3:0] id, input string tag);
    s_bvalid = 1'b1; s_bresp = RESP_OKAY; s_bid = id;
    #1;
    check_eq({tag, " s_bready"}, s_bready, 1'b1);
    if (m == 0) begin
      check_eq({tag, " m0_bvalid"}, m0_bvalid, 1'b1);
      check_eq({tag, " m0_bid"}, m0_bid, id);
      check_eq({tag, " m1_bvalid"}, m1_bvalid, 1'b0);
    end else begin
      check_eq({tag, " m1_bvalid"}, m1_bvalid, 1'b1);
      check_eq({tag, " m1_bid"}, m1_bid, id);
      check_eq({tag, " m1_bresp"}, m1_bresp, RESP_OKAY);
      check_eq({tag, " m0_bvalid"}, m0_bvalid, 1'b0);
    end
    tick();
    s_bvalid = 1'b0; s_bid = '0;
  endtask

  initial begin
    aresetn = 1'b0;
    set_ar(0, 0, '0, '0, '0); set_ar(1, 0, '0, '0, '0);
    set_aw(0, 0, '0); set_aw(1, 0, '0);
    set_w(0, 0, '0, '0); set_w(1, 0, '0, '0);
    m0_rready = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1; m1_bready = 1'b1;
    s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_rdata = '0; s_rid = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
    tick(); tick(); tick();

    check_eq("rst s_arvalid", s_arvalid, 1'b0);
    check_eq("rst s_awvalid", s_awvalid, 1'b0);
    check_eq("rst s_wvalid", s_wvalid, 1'b0);
    check_eq("rst s_rready", s_rready, 1'b0);
    check_eq("rst s_bready", s_bready, 1'b0);
    check_eq("rst m0_arready", m0_arready, 1'b0);
    check_eq("rst s_araddr", s_araddr, 32'h0);
    aresetn = 1'b1;
    tick();

    // Single read from M0
    s_arready = 1'b1;
    set_ar(0, 1, 32'h8000_0000, 8'd0, 3'd2);
    #1;
    check_eq("rd1 s_arvalid same cycle", s_arvalid, 1'b0);
    tick();
    check_eq("rd1 s_arvalid", s_arvalid, 1'b1);
    check_eq("rd1 s_araddr", s_araddr, 32'h8000_0000);
    check_eq("rd1 s_arid", s_arid, 4'h1);
    check_eq("rd1 m0_arready", m0_arready, 1'b1);
    check_eq("rd1 m1_arready", m1_arready, 1'b0);
    tick();
    set_ar(0, 0, '0, '0, '0);
    r_beat(0, 64'h0000_0413, 1'b1, "rd1");
    s_rvalid = 1'b1;
    #1;
    check_eq("rd1 idle s_rready", s_rready, 1'b0);
    check_eq("rd1 idle m0_rvalid", m0_rvalid, 1'b0);
    s_rvalid = 1'b0;

    // Contention right after reset: M0, then M1, then M0 again
    aresetn = 1'b0; tick(); aresetn = 1'b1;
    set_ar(0, 1, 32'h8000_0100, 8'd0, 3'd3);
    set_ar(1, 1, 32'h8000_0200, 8'd0, 3'd3);
    tick();
    check_eq("cont1 s_araddr", s_araddr, 32'h8000_0100);
    check_eq("cont1 m1_arready", m1_arready, 1'b0);
    tick();
    set_ar(0, 0, '0, '0, '0);
    r_beat(0, 64'h100, 1'b1, "cont1");
    tick();
    check_eq("cont2 s_araddr", s_araddr, 32'h8000_0200);
    check_eq("cont2 m1_arready", m1_arready, 1'b1);
    tick();
    set_ar(1, 0, '0, '0, '0);
    r_beat(1, 64'h200, 1'b1, "cont2");
    set_ar(0, 1, 32'h8000_0100, 8'd0, 3'd3);
    set_ar(1, 1, 32'h8000_0200, 8'd0, 3'd3);
    tick();
    check_eq("cont3 s_araddr", s_araddr, 32'h8000_0100);
    set_ar(1, 0, '0, '0, '0);
    tick();
    set_ar(0, 0, '0, '0, '0);
    r_beat(0, 64'h101, 1'b1, "cont3");

    // 4-beat burst to M1 with M0 waiting
    set_ar(1, 1, 32'h8000_1000, 8'd3, 3'd3);
    tick();
    check_eq("burst s_araddr", s_araddr, 32'h8000_1000);
    check_eq("burst s_arlen", s_arlen, 8'd3);
    check_eq("burst s_arsize", s_arsize, 3'd3);
    tick();
    set_ar(1, 0, '0, '0, '0);
    set_ar(0, 1, 32'h8000_0040, 8'd0, 3'd3);
    for (int i = 0; i < 4; i++) begin
      check_eq("burst m0 stalled", m0_arready, 1'b0);
      check_eq("burst s_arvalid", s_arvalid, 1'b0);
      r_beat(1, 64'h1000 + 64'(i), (i == 3), "burst");
    end
    check_eq("burst after m0_arready", m0_arready, 1'b0);
    tick();
    check_eq("burst m0 granted", m0_arready, 1'b1);
    check_eq("burst m0 s_araddr", s_araddr, 32'h8000_0040);
    tick();
    set_ar(0, 0, '0, '0, '0);
    r_beat(0, 64'h40, 1'b1, "burst m0");

    // Write from M1 with awready delayed two cycles
    set_aw(1, 1, 32'h8000_2000);
    set_w(1, 1, 64'hDEAD_BEEF, 8'h0F);
    tick();
    check_eq("wr s_awvalid", s_awvalid, 1'b1);
    check_eq("wr s_wvalid", s_wvalid, 1'b1);
    check_eq("wr s_awaddr", s_awaddr, 32'h8000_2000);
    check_eq("wr s_wdata", s_wdata, 64'hDEAD_BEEF);
    check_eq("wr s_wstrb", s_wstrb, 8'h0F);
    check_eq("wr s_wlast", s_wlast, 1'b1);
    check_eq("wr m1_awready wait", m1_awready, 1'b0);
    tick();
    check_eq("wr s_awvalid hold", s_awvalid, 1'b1);
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    check_eq("wr m1_awready", m1_awready, 1'b1);
    check_eq("wr m1_wready", m1_wready, 1'b1);
    check_eq("wr m0_wready", m0_wready, 1'b0);
    tick();
    set_aw(1, 0, '0); set_w(1, 0, '0, '0);
    b_beat(1, 4'h4, "wr");
    s_bvalid = 1'b1;
    #1;
    check_eq("wr idle s_bready", s_bready, 1'b0);
    check_eq("wr idle m1_bvalid", m1_bvalid, 1'b0);
    s_bvalid = 1'b0;

    // M0 read and M1 write in the same cycle
    set_ar(0, 1, 32'h8000_0080, 8'd0, 3'd3);
    set_aw(1, 1, 32'h8000_2040);
    set_w(1, 1, 64'h1234_5678, 8'hFF);
    tick();
    check_eq("conc s_arvalid", s_arvalid, 1'b1);
    check_eq("conc s_awvalid", s_awvalid, 1'b1);
    check_eq("conc s_wvalid", s_wvalid, 1'b1);
    tick();
    set_ar(0, 0, '0, '0, '0); set_aw(1, 0, '0); set_w(1, 0, '0, '0);
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h80;
    s_bvalid = 1'b1; s_bresp = RESP_OKAY; s_bid = 4'h4;
    #1;
    check_eq("conc m0_rvalid", m0_rvalid, 1'b1);
    check_eq("conc m1_bvalid", m1_bvalid, 1'b1);
    check_eq("conc s_rready", s_rready, 1'b1);
    check_eq("conc s_bready", s_bready, 1'b1);
    tick();
    check_eq("conc done s_rready", s_rready, 1'b0);
    check_eq("conc done s_bready", s_bready, 1'b0);
    s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0;

    // AW accepted before W: awvalid is fenced once aw_done
    s_awready = 1'b1; s_wready = 1'b0;
    set_aw(0, 1, 32'h8000_3000);
    set_w(0, 1, 64'hCAFE, 8'hFF);
    tick();
    check_eq("awd m0_awready", m0_awready, 1'b1);
    check_eq("awd s_awaddr", s_awaddr, 32'h8000_3000);
    tick();
    check_eq("awd s_awvalid fenced", s_awvalid, 1'b0);
    check_eq("awd m0_awready fenced", m0_awready, 1'b0);
    check_eq("awd s_wvalid", s_wvalid, 1'b1);
    s_wready = 1'b1;
    #1;
    check_eq("awd m0_wready", m0_wready, 1'b1);
    tick();
    set_aw(0, 0, '0); set_w(0, 0, '0, '0);
    check_eq("awd resp s_wvalid", s_wvalid, 1'b0);
    b_beat(0, 4'h3, "awd");

    // Reset during beat 2 of a 4-beat M0 read
    set_ar(0, 1, 32'h8000_4000, 8'd3, 3'd3);
    tick(); tick();
    set_ar(0, 0, '0, '0, '0);
    r_beat(0, 64'h4000, 1'b0, "rstb b1");
    s_rvalid = 1'b1; s_rdata = 64'h4008; s_rlast = 1'b0;
    aresetn = 1'b0;
    #1;
    check_eq("rstb b2 m0_rvalid", m0_rvalid, 1'b1);
    tick();
    check_eq("rstb s_rready", s_rready, 1'b0);
    check_eq("rstb m0_rvalid", m0_rvalid, 1'b0);
    check_eq("rstb m0_rdata", m0_rdata, 64'h0);
    check_eq("rstb s_arvalid", s_arvalid, 1'b0);
    check_eq("rstb s_awvalid", s_awvalid, 1'b0);
    check_eq("rstb s_bready", s_bready, 1'b0);
    aresetn = 1'b1;
    s_rvalid = 1'b0; s_rdata = '0;
    set_ar(0, 1, 32'h8000_0100, 8'd0, 3'd3);
    set_ar(1, 1, 32'h8000_0200, 8'd0, 3'd3);
    tick();
    check_eq("rstb pointer s_araddr", s_araddr, 32'h8000_0100);
    check_eq("rstb pointer m1_arready", m1_arready, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
